svc_rv_regfile: RTL and testbench
=================================

Name: svc_rv_regfile

Overview:
- Integer register file for the svc_rv RISC-V core; the consumer of the write-back result stream (rd_en/rd_addr/rd_data from WB) and the source of rs1/rs2 operands for the ID stage.
- Two read ports and one write port, with x0 hardwired to zero.
- Optional same-cycle write-to-read bypass.
- Read timing is selectable:
  - combinational (LUTRAM style), or
  - registered (BRAM style), with stall/hold.

Parameters:
- XLEN, 32, register width in bits.
- NREGS, 32, number of architectural registers; 32 for RV32I, 16 for RV32E.
- FWD, 1, 1 = write data in the same cycle bypasses to the read outputs.
- RD_REG, 0, 0 = combinational read; 1 = read data registered, valid one cycle after the address.

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- rs_en  input  1  read advance; ID stage not stalled (used only when RD_REG=1)
- rs1_addr  input  5  source register 1 index
- rs2_addr  input  5  source register 2 index
- rs1_data  output  XLEN  source register 1 value
- rs2_data  output  XLEN  source register 2 value
- rd_en  input  1  write enable from WB (reg_write && valid)
- rd_addr  input  5  destination register index
- rd_data  input  XLEN  write-back value (rd_data_wb)

Behaviour:
- Reset: rst_n low asynchronously clears all NREGS registers and both registered outputs (RD_REG=1) to 0.
  - Reset asserted mid-operation discards any write in that cycle.
  - Writes are accepted from the first clk edge after rst_n deasserts.
- Write:
  - On posedge clk, if rd_en && rd_addr != 0 && rd_addr < NREGS, then regs[rd_addr] <= rd_data.
  - Otherwise no state change. Writes to x0 or to indices >= NREGS are silently dropped.
- Read value function, for address a:
  - a == 0 or a >= NREGS: 0.
  - else if FWD && rd_en && rd_addr == a: rd_data (bypass).
  - else regs[a].
- RD_REG=0:
  - rsN_data = read value of rsN_addr, combinationally, same cycle.
  - rs_en is ignored.
- RD_REG=1:
  - On posedge clk with rs_en=1, rsN_data <= read value of rsN_addr, with the bypass evaluated in that cycle. Latency is 1 cycle.
  - With rs_en=0 the block latches the address of each output (internal latched_addrN). rsN_data holds its value, except when rd_en && rd_addr == latched_addrN && rd_addr != 0 && rd_addr < NREGS; then rsN_data <= rd_data.
  - This hold-refresh happens regardless of FWD, so a stalled consumer never sees stale data after WB retires its producer.
  - The latched address updates only when rs_en=1. It resets to 0.
- Both read ports are independent. rs1_addr == rs2_addr returns identical data on both.
- Simultaneous write and read of the same register:
  - FWD=1: new value.
  - FWD=0: old value. This holds for the RD_REG=1 capture path too; the hold-refresh is the exception above.
- Address bits above log2(NREGS) are not truncated. An out-of-range index reads 0 and writes are dropped.

Test Plan:
- Reset sweep: assert rst_n=0 after writing x5=0xDEADBEEF. Read x1..x31 -> all 0; in RD_REG=1, rs1_data/rs2_data = 0 immediately, without waiting for a clock.
- x0 immunity: write rd_addr=0, rd_data=0x12345678, then read rs1_addr=0 -> 0, in both FWD settings and both RD_REG settings.
- Bypass, FWD=1, RD_REG=0: in one cycle, rd_en=1, rd_addr=7, rd_data=0xA5A5A5A5, rs1_addr=rs2_addr=7 -> both outputs 0xA5A5A5A5 that cycle. With FWD=0 -> prior value 0 that cycle, 0xA5A5A5A5 the next cycle.
- Registered stall refresh, RD_REG=1:
  - Capture rs1_addr=3 (value 0x11) with rs_en=1, then hold rs_en=0 for 3 cycles. During cycle 2, write x3=0x22.
  - rs1_data = 0x11 until the write edge, then 0x22.
  - A write to x4 during the stall leaves rs1_data unchanged.
- RV32E bounds, NREGS=16: write rd_addr=20, rd_data=0xFF, then read rs2_addr=20 -> 0. Write x15=0x7 and read it back -> 0x7.
- Random: 10k cycles of random writes and reads against a reference model. Covers all reads and rs_en toggling, with zero mismatches.

Source files
------------

// File: rtl/svc_rv_regfile.sv
// Integer register file for the svc_rv core: two read ports, one write port, x0 hardwired to zero.
// Read data is either combinational or registered with stall hold and write-back refresh.
module svc_rv_regfile #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int FWD    = 1,
    parameter int RD_REG = 0
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_rs_en,
    input  logic [4:0]      i_rs1_addr,
    input  logic [4:0]      i_rs2_addr,
    output logic [XLEN-1:0] o_rs1_data,
    output logic [XLEN-1:0] o_rs2_data,
    input  logic            i_rd_en,
    input  logic [4:0]      i_rd_addr,
    input  logic [XLEN-1:0] i_rd_data
);

    localparam int         AW      = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [5:0] NREGS_W = 6'(NREGS);

    // Out-of-range indices are compared on the full address, never truncated.
    function automatic logic in_range(input logic [4:0] a);
        return (a != 5'd0) && ({1'b0, a} < NREGS_W);
    endfunction

    logic [XLEN-1:0] r_regs [NREGS];
    logic            w_wr_ok;
    logic [XLEN-1:0] w_rd1;
    logic [XLEN-1:0] w_rd2;

    assign w_wr_ok = i_rd_en && in_range(i_rd_addr);

    // Register array update; x0 is reset and never written.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_regs[i_rd_addr[AW-1:0]] <= i_rd_data;
        end
    end

    // Read value for both ports, with optional same-cycle bypass.
    always_comb begin
        w_rd1 = '0;
        w_rd2 = '0;
        if (in_range(i_rs1_addr)) begin
            if ((FWD != 0) && w_wr_ok && (i_rd_addr == i_rs1_addr)) begin
                w_rd1 = i_rd_data;
            end else begin
                w_rd1 = r_regs[i_rs1_addr[AW-1:0]];
            end
        end else begin
            w_rd1 = '0;
        end
        if (in_range(i_rs2_addr)) begin
            if ((FWD != 0) && w_wr_ok && (i_rd_addr == i_rs2_addr)) begin
                w_rd2 = i_rd_data;
            end else begin
                w_rd2 = r_regs[i_rs2_addr[AW-1:0]];
            end
        end else begin
            w_rd2 = '0;
        end
    end

    if (RD_REG != 0) begin : g_reg
        logic [4:0]      r_la1;
        logic [4:0]      r_la2;
        logic [XLEN-1:0] r_q1;
        logic [XLEN-1:0] r_q2;

        // Capture on advance; while stalled, refresh from write-back so the held value never goes stale.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_la1 <= 5'd0;
                r_la2 <= 5'd0;
                r_q1  <= '0;
                r_q2  <= '0;
            end else if (i_rs_en) begin
                r_la1 <= i_rs1_addr;
                r_la2 <= i_rs2_addr;
                r_q1  <= w_rd1;
                r_q2  <= w_rd2;
            end else begin
                if (w_wr_ok && (i_rd_addr == r_la1)) begin
                    r_q1 <= i_rd_data;
                end else begin
                    r_q1 <= r_q1;
                end
                if (w_wr_ok && (i_rd_addr == r_la2)) begin
                    r_q2 <= i_rd_data;
                end else begin
                    r_q2 <= r_q2;
                end
            end
        end

        assign o_rs1_data = r_q1;
        assign o_rs2_data = r_q2;
    end else begin : g_comb
        logic w_unused_rs_en;
        assign w_unused_rs_en = i_rs_en;
        assign o_rs1_data     = w_rd1;
        assign o_rs2_data     = w_rd2;
    end

endmodule

// File: tb/tb_svc_rv_regfile.sv
// Bench for svc_rv_regfile: four configurations share one stimulus stream,
// directed vectors with fixed expectations followed by a random run against a reference model.
module tb_svc_rv_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rs_en;
    logic        rd_en;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [31:0] w_o1 [4];
    logic [31:0] w_o2 [4];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    // u0: FWD=1 comb, u1: FWD=0 comb, u2: FWD=1 registered, u3: FWD=0 registered RV32E
    svc_rv_regfile #(.XLEN(32), .NREGS(32), .FWD(1), .RD_REG(0)) u0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_rs_en(rs_en), .i_rs1_addr(rs1), .i_rs2_addr(rs2),
        .o_rs1_data(w_o1[0]), .o_rs2_data(w_o2[0]), .i_rd_en(rd_en), .i_rd_addr(rd_addr), .i_rd_data(rd_data));
    svc_rv_regfile #(.XLEN(32), .NREGS(32), .FWD(0), .RD_REG(0)) u1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_rs_en(rs_en), .i_rs1_addr(rs1), .i_rs2_addr(rs2),
        .o_rs1_data(w_o1[1]), .o_rs2_data(w_o2[1]), .i_rd_en(rd_en), .i_rd_addr(rd_addr), .i_rd_data(rd_data));
    svc_rv_regfile #(.XLEN(32), .NREGS(32), .FWD(1), .RD_REG(1)) u2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_rs_en(rs_en), .i_rs1_addr(rs1), .i_rs2_addr(rs2),
        .o_rs1_data(w_o1[2]), .o_rs2_data(w_o2[2]), .i_rd_en(rd_en), .i_rd_addr(rd_addr), .i_rd_data(rd_data));
    svc_rv_regfile #(.XLEN(32), .NREGS(16), .FWD(0), .RD_REG(1)) u3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_rs_en(rs_en), .i_rs1_addr(rs1), .i_rs2_addr(rs2),
        .o_rs1_data(w_o1[3]), .o_rs2_data(w_o2[3]), .i_rd_en(rd_en), .i_rd_addr(rd_addr), .i_rd_data(rd_data));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model
    logic [31:0] m_regs [4][32];
    logic [31:0] m_q1 [4];
    logic [31:0] m_q2 [4];
    logic [4:0]  m_la1 [4];
    logic [4:0]  m_la2 [4];

    function automatic bit fwd_of(input int k);
        return (k == 0) || (k == 2);
    endfunction
    function automatic bit rdr_of(input int k);
        return k >= 2;
    endfunction
    function automatic int nr_of(input int k);
        return (k == 3) ? 16 : 32;
    endfunction
    function automatic bit ok_of(input int k, input logic [4:0] a);
        return (a != 5'd0) && (int'(a) < nr_of(k));
    endfunction

    function automatic logic [31:0] model_rd(input int k, input logic [4:0] a);
        if (!ok_of(k, a)) return 32'd0;
        if (fwd_of(k) && rd_en && (rd_addr == a)) return rd_data;
        return m_regs[k][a];
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 4; k++) begin
            for (int r = 0; r < 32; r++) m_regs[k][r] = 32'd0;
            m_q1[k] = 32'd0; m_q2[k] = 32'd0; m_la1[k] = 5'd0; m_la2[k] = 5'd0;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 4; k++) begin
            if (rdr_of(k)) begin
                if (rs_en) begin
                    m_q1[k] = model_rd(k, rs1); m_la1[k] = rs1;
                    m_q2[k] = model_rd(k, rs2); m_la2[k] = rs2;
                end else begin
                    if (rd_en && ok_of(k, rd_addr) && (rd_addr == m_la1[k])) m_q1[k] = rd_data;
                    if (rd_en && ok_of(k, rd_addr) && (rd_addr == m_la2[k])) m_q2[k] = rd_data;
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (rd_en && ok_of(k, rd_addr)) m_regs[k][rd_addr] = rd_data;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; rs_en = 1'b0; rd_en = 1'b0;
        rs1 = 5'd0; rs2 = 5'd0; rd_addr = 5'd0; rd_data = 32'd0;
        #2;
        for (int k = 0; k < 4; k++) begin
            check("rst_init_rs1", w_o1[k], 32'd0);
            check("rst_init_rs2", w_o2[k], 32'd0);
        end
        @(negedge clk); rst_n = 1'b1;
        tick();

        // Write x5, then assert reset asynchronously
        rd_en = 1'b1; rd_addr = 5'd5; rd_data = 32'hDEADBEEF;
        tick();
        rd_en = 1'b0; rs1 = 5'd5; rs2 = 5'd5; rs_en = 1'b1;
        #1;
        check("x5_comb", w_o1[0], 32'hDEADBEEF);
        tick();
        check("x5_reg_u2", w_o1[2], 32'hDEADBEEF);
        check("x5_reg_u3", w_o2[3], 32'hDEADBEEF);
        rst_n = 1'b0;
        #1;
        check("rst_async_u2_rs1", w_o1[2], 32'd0);
        check("rst_async_u2_rs2", w_o2[2], 32'd0);
        check("rst_async_u3_rs1", w_o1[3], 32'd0);
        check("rst_async_u3_rs2", w_o2[3], 32'd0);
        check("rst_async_comb", w_o1[0], 32'd0);
        for (int a = 1; a < 32; a++) begin
            rs1 = 5'(a); rs2 = 5'(32 - a);
            #1;
            check("rst_sweep_u0", w_o1[0], 32'd0);
            check("rst_sweep_u1", w_o2[1], 32'd0);
        end
        @(negedge clk); rst_n = 1'b1;
        tick();

        // x0 immunity
        rs_en = 1'b1; rd_en = 1'b1; rd_addr = 5'd0; rd_data = 32'h12345678; rs1 = 5'd0;
        #1;
        check("x0_u0", w_o1[0], 32'd0);
        check("x0_u1", w_o1[1], 32'd0);
        tick();
        rd_en = 1'b0;
        #1;
        check("x0_u2", w_o1[2], 32'd0);
        check("x0_u3", w_o1[3], 32'd0);

        // Same-cycle bypass on x7
        rd_en = 1'b1; rd_addr = 5'd7; rd_data = 32'hA5A5A5A5; rs1 = 5'd7; rs2 = 5'd7;
        #1;
        check("byp_fwd_rs1", w_o1[0], 32'hA5A5A5A5);
        check("byp_fwd_rs2", w_o2[0], 32'hA5A5A5A5);
        check("byp_nofwd_rs1", w_o1[1], 32'd0);
        check("byp_nofwd_rs2", w_o2[1], 32'd0);
        tick();
        check("byp_reg_fwd", w_o1[2], 32'hA5A5A5A5);
        check("byp_reg_nofwd_old", w_o1[3], 32'd0);
        rd_en = 1'b0;
        #1;
        check("byp_nofwd_next", w_o1[1], 32'hA5A5A5A5);
        tick();
        check("byp_reg_nofwd_next", w_o1[3], 32'hA5A5A5A5);
        check("byp_reg_nofwd_rs2", w_o2[3], 32'hA5A5A5A5);

        // Stall with write-back refresh
        rs_en = 1'b0; rd_en = 1'b1; rd_addr = 5'd3; rd_data = 32'h11;
        tick();
        rd_en = 1'b0; rs1 = 5'd3; rs2 = 5'd4; rs_en = 1'b1;
        tick();
        check("cap_u2_rs1", w_o1[2], 32'h11);
        check("cap_u3_rs1", w_o1[3], 32'h11);
        check("cap_u2_rs2", w_o2[2], 32'd0);
        rs_en = 1'b0; rs1 = 5'd9; rs2 = 5'd10;
        tick();
        check("stall1_u2", w_o1[2], 32'h11);
        check("stall1_u3", w_o1[3], 32'h11);
        rd_en = 1'b1; rd_addr = 5'd3; rd_data = 32'h22;
        #1;
        check("stall2_pre_u3", w_o1[3], 32'h11);
        tick();
        check("stall2_refresh_u2", w_o1[2], 32'h22);
        check("stall2_refresh_u3", w_o1[3], 32'h22);
        rd_addr = 5'd4; rd_data = 32'h44;
        tick();
        check("stall3_rs1_u2", w_o1[2], 32'h22);
        check("stall3_rs1_u3", w_o1[3], 32'h22);
        check("stall3_rs2_u2", w_o2[2], 32'h44);
        check("stall3_rs2_u3", w_o2[3], 32'h44);

        // RV32E bounds
        rd_en = 1'b1; rd_addr = 5'd20; rd_data = 32'hFF;
        tick();
        rd_addr = 5'd15; rd_data = 32'h7;
        tick();
        rd_en = 1'b0; rs1 = 5'd15; rs2 = 5'd20; rs_en = 1'b1;
        tick();
        check("e_x15_u3", w_o1[3], 32'h7);
        check("e_x20_u3", w_o2[3], 32'd0);
        check("e_x15_u2", w_o1[2], 32'h7);
        check("e_x20_u2", w_o2[2], 32'hFF);
        check("e_x20_u0", w_o2[0], 32'hFF);

        // Random run against the model
        rst_n = 1'b0;
        model_clear();
        rs_en = 1'b0; rd_en = 1'b0; rs1 = 5'd0; rs2 = 5'd0; rd_addr = 5'd0; rd_data = 32'd0;
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            int sel;
            @(posedge clk);
            model_edge();
            #1;
            rs_en   = ($urandom_range(0, 3) != 0);
            rd_en   = 1'($urandom_range(0, 1));
            rs1     = 5'($urandom_range(0, 31));
            rs2     = 5'($urandom_range(0, 31));
            rd_data = $urandom;
            sel     = int'($urandom_range(0, 3));
            case (sel)
                0:       rd_addr = rs1;
                1:       rd_addr = rs2;
                2:       rd_addr = m_la1[3];
                default: rd_addr = 5'($urandom_range(0, 31));
            endcase
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                check("rnd_rs1", w_o1[k], rdr_of(k) ? m_q1[k] : model_rd(k, rs1));
                check("rnd_rs2", w_o2[k], rdr_of(k) ? m_q2[k] : model_rd(k, rs2));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
